inc_sat_counter: RTL and testbench

INC_SAT_COUNTER -- requirements
Module: inc_sat_counter

---
 rtl/rv_ic_pkg.sv | 19 +
 rtl/inc_sat_counter_add1.sv | 12 +
 rtl/inc_sat_counter.sv | 73 +++++++
 tb/tb_inc_sat_counter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/rv_ic_pkg.sv
// Shared definitions for the saturating increment counter: FSM state encodings
// and a helper that classifies a count value into its state.
package rv_ic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } state_e;

    function automatic state_e state_of(input logic is_zero, input logic is_limit);
        state_e s;
        if (is_zero)       s = IDLE;
        else if (is_limit) s = SAT;
        else               s = RUN;
        return s;
    endfunction

endpackage

// File: rtl/inc_sat_counter_add1.sv
// Combinational +1 block; holds at all-ones rather than rolling over, mirroring
// the existing decrement block.
module Add1 #(
    parameter int N = 4
) (
    input  logic [N-1:0] Vin,
    output logic [N-1:0] Vout
);

    assign Vout = (Vin == {N{1'b1}}) ? {N{1'b1}} : Vin + N'(1);

endmodule

// File: rtl/inc_sat_counter.sv
// Saturating up-counter with clear/load and a valid/ready increment port.
// Define INC_SAT_WRAP_EN to let an increment in SAT wrap the count back to 0.
module inc_sat_counter
    import rv_ic_pkg::*;
#(
    parameter int N     = 4,
    parameter int LIMIT = 2**N - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] Din,
    input  logic         inc_valid,
    output logic         inc_ready,
    output logic [N-1:0] Vout,
    output logic         sat,
    output logic         sat_pulse
);

    localparam logic [N-1:0] LIM = N'(LIMIT);

    state_e       state_q, state_d;
    logic [N-1:0] vout_q, vout_d;
    logic         sat_pulse_q, sat_pulse_d;
    logic [N-1:0] add_out;
    logic         wrap_now;

    Add1 #(.N(N)) u_add1 (
        .Vin  (vout_q),
        .Vout (add_out)
    );

`ifdef INC_SAT_WRAP_EN
    assign inc_ready = 1'b1;
    assign wrap_now  = (state_q == SAT);
`else
    assign inc_ready = (state_q != SAT);
    assign wrap_now  = 1'b0;
`endif

    // clr beats load beats increment; an increment is only taken below LIMIT
    // unless the wrap build lets SAT roll over to zero.
    always_comb begin
        vout_d = vout_q;
        if (clr)
            vout_d = '0;
        else if (load)
            vout_d = (Din > LIM) ? LIM : Din;
        else if (inc_valid && inc_ready)
            vout_d = wrap_now ? '0 : add_out;

        state_d     = state_of(vout_d == '0, vout_d == LIM);
        sat_pulse_d = (vout_d == LIM) && (state_q != SAT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vout_q      <= '0;
            sat_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vout_q      <= vout_d;
            sat_pulse_q <= sat_pulse_d;
        end
    end

    assign Vout      = vout_q;
    assign sat       = (state_q == SAT);
    assign sat_pulse = sat_pulse_q;

endmodule

// File: tb/tb_inc_sat_counter.sv
// Directed, table-driven bench for inc_sat_counter: one instance at LIMIT=15
// and one at LIMIT=10; expectations follow INC_SAT_WRAP_EN when it is defined.
module tb_inc_sat_counter;

`ifdef INC_SAT_WRAP_EN
    localparam bit W = 1'b1;
`else
    localparam bit W = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       clr;
        logic       load;
        logic [3:0] din;
        logic       inc;
        logic [3:0] vout;
        logic       ready;
        logic       sat;
        logic       pulse;
    } vec_t;

    logic       clk;
    logic       a_rst, a_clr, a_load, a_inc, a_ready, a_sat, a_pulse;
    logic [3:0] a_din, a_vout;
    logic       b_rst, b_clr, b_load, b_inc, b_ready, b_sat, b_pulse;
    logic [3:0] b_din, b_vout;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    inc_sat_counter #(.N(4)) dut_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .load(a_load), .Din(a_din),
        .inc_valid(a_inc), .inc_ready(a_ready), .Vout(a_vout),
        .sat(a_sat), .sat_pulse(a_pulse)
    );

    inc_sat_counter #(.N(4), .LIMIT(10)) dut_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .load(b_load), .Din(b_din),
        .inc_valid(b_inc), .inc_ready(b_ready), .Vout(b_vout),
        .sat(b_sat), .sat_pulse(b_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(bit r, bit c, bit l, int din, bit inc,
                                   int vout, bit rdy, bit st, bit pls);
        vec_t v;
        v.rst = r;  v.clr = c;  v.load = l;  v.din = 4'(din);  v.inc = inc;
        v.vout = 4'(vout);  v.ready = rdy;  v.sat = st;  v.pulse = pls;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one record into the selected instance, clock it, check just after the edge.
    task automatic applyStimulus(input bit sel_b, input vec_t v, input string tag);
        if (sel_b) begin
            b_rst = v.rst; b_clr = v.clr; b_load = v.load; b_din = v.din; b_inc = v.inc;
        end else begin
            a_rst = v.rst; a_clr = v.clr; a_load = v.load; a_din = v.din; a_inc = v.inc;
        end
        @(posedge clk);
        #1;
        if (sel_b) begin
            checkOutput({tag, " Vout"},      8'(b_vout),  8'(v.vout));
            checkOutput({tag, " inc_ready"}, 8'(b_ready), 8'(v.ready));
            checkOutput({tag, " sat"},       8'(b_sat),   8'(v.sat));
            checkOutput({tag, " sat_pulse"}, 8'(b_pulse), 8'(v.pulse));
        end else begin
            checkOutput({tag, " Vout"},      8'(a_vout),  8'(v.vout));
            checkOutput({tag, " inc_ready"}, 8'(a_ready), 8'(v.ready));
            checkOutput({tag, " sat"},       8'(a_sat),   8'(v.sat));
            checkOutput({tag, " sat_pulse"}, 8'(a_pulse), 8'(v.pulse));
        end
        a_rst = 0; a_clr = 0; a_load = 0; a_inc = 0;
        b_rst = 0; b_clr = 0; b_load = 0; b_inc = 0;
    endtask

    initial begin
        a_rst = 0; a_clr = 0; a_load = 0; a_din = 0; a_inc = 0;
        b_rst = 0; b_clr = 0; b_load = 0; b_din = 0; b_inc = 0;

        // LIMIT = 15 table: count to saturation, then command priority cases.
        vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 1; i <= 15; i++)
            vecs.push_back(mkVec(0, 0, 0, 0, 1, i, (i < 15) ? 1'b1 : W, i == 15, i == 15));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, W ? 0 : 15, W, !W, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, W ? 1 : 15, W, !W, 0));
        vecs.push_back(mkVec(0, 0, 1, 5, 0, 5, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 1, 9, 1, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, 0, 1, 7, 0, 7, 1, 0, 0));
        vecs.push_back(mkVec(1, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, 0, 1, 15, 0, 15, W, 1, 1));
        vecs.push_back(mkVec(0, 0, 1, 15, 0, 15, W, 1, 0));
        vecs.push_back(mkVec(0, 0, 1, 3, 1, 3, 1, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 3, 1, 0, 0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, 1, 1, 0, 0));

        #2;
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(1'b0, vecs[i], $sformatf("A[%0d]", i));

        // LIMIT = 10: load near the limit, step into saturation, over-limit loads.
        applyStimulus(1'b1, mkVec(1, 0, 0, 0, 0, 0, 1, 0, 0), "B reset");
        applyStimulus(1'b1, mkVec(0, 0, 1, 9, 0, 9, 1, 0, 0), "B load9");
        applyStimulus(1'b1, mkVec(0, 0, 0, 0, 1, 10, W, 1, 1), "B inc1");
        applyStimulus(1'b1, mkVec(0, 0, 0, 0, 1, W ? 0 : 10, W, !W, 0), "B inc2");
        applyStimulus(1'b1, mkVec(0, 1, 0, 0, 0, 0, 1, 0, 0), "B clr");
        applyStimulus(1'b1, mkVec(0, 0, 1, 14, 0, 10, W, 1, 1), "B load14");
        applyStimulus(1'b1, mkVec(0, 0, 1, 14, 0, 10, W, 1, 0), "B load14 again");

        // inc_ready must still show the saturated state while clr is pending.
        b_clr = 1; b_inc = 1;
        #1;
        checkOutput("B ready under clr", 8'(b_ready), 8'(W));
        applyStimulus(1'b1, mkVec(0, 1, 0, 0, 1, 0, 1, 0, 0), "B clr+inc");
        applyStimulus(1'b1, mkVec(0, 0, 0, 0, 0, 0, 1, 0, 0), "B idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
